// File: rtl/uart_tx_buffered.sv
// FIFO-buffered 8N1 UART transmitter: bytes are queued over a valid/ready handshake
// and drained back-to-back onto RsTx.
module uart_tx_buffered #(
    parameter int CLKS_PER_BIT = 10416,
    parameter int FIFO_DEPTH   = 16,
    parameter int STOP_BITS    = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [7:0]                    in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic                          RsTx,
    output logic                          busy,
    output logic                          tx_done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = $clog2(CLKS_PER_BIT);

    localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);
    localparam logic [BW-1:0] BAUD_LAST  = BW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]    STOP_LAST  = 3'(STOP_BITS - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t          state;
    logic [7:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [7:0]      shreg;
    logic [BW-1:0]   baud;
    logic [2:0]      bit_idx;
    logic            push;
    logic            pop;
    logic            baud_last;

    assign in_ready  = (fifo_count != FULL_COUNT) && rst_n;
    assign push      = in_valid && in_ready;
    assign pop       = (state == IDLE) && (fifo_count != '0);
    assign baud_last = (baud == BAUD_LAST);

    // Storage has no reset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Outputs are registered from the current state, so the line trails the FSM by one clk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            shreg   <= '0;
            baud    <= '0;
            bit_idx <= '0;
            RsTx    <= 1'b1;
            busy    <= 1'b0;
            tx_done <= 1'b0;
        end else begin
            busy    <= (state != IDLE);
            tx_done <= 1'b0;
            case (state)
                IDLE: begin
                    RsTx    <= 1'b1;
                    baud    <= '0;
                    bit_idx <= '0;
                    if (pop) begin
                        shreg <= mem[rd_ptr];
                        state <= START;
                    end
                end
                START: begin
                    RsTx <= 1'b0;
                    if (baud_last) begin
                        baud  <= '0;
                        state <= DATA;
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
                DATA: begin
                    RsTx <= shreg[bit_idx];
                    if (baud_last) begin
                        baud <= '0;
                        if (bit_idx == 3'd7) begin
                            bit_idx <= '0;
                            state   <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
                STOP: begin
                    RsTx <= 1'b1;
                    if (baud_last) begin
                        baud <= '0;
                        if (bit_idx == STOP_LAST) begin
                            bit_idx <= '0;
                            tx_done <= 1'b1;
                            state   <= IDLE;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
                default: begin
                    RsTx  <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Scoreboard bench for uart_tx_buffered: accepted bytes are queued as expectations
// and a line monitor decodes each frame off RsTx and compares in order.
module tb_uart_tx_buffered;

    localparam int C     = 4;
    localparam int DEPTH = 4;
    localparam int FRAME = 10 * C;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       RsTx;
    logic       busy;
    logic       tx_done;
    logic [2:0] fifo_count;

    logic [7:0] in_data2;
    logic       in_valid2;
    logic       in_ready2;
    logic       RsTx2;
    logic       busy2;
    logic       tx_done2;
    logic [2:0] fifo_count2;

    int checks = 0;
    int errors = 0;
    logic [7:0] expQ[$];

    uart_tx_buffered #(.CLKS_PER_BIT(C), .FIFO_DEPTH(DEPTH), .STOP_BITS(1)) u1 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .RsTx(RsTx), .busy(busy), .tx_done(tx_done),
        .fifo_count(fifo_count)
    );

    uart_tx_buffered #(.CLKS_PER_BIT(C), .FIFO_DEPTH(DEPTH), .STOP_BITS(2)) u2 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data2), .in_valid(in_valid2),
        .in_ready(in_ready2), .RsTx(RsTx2), .busy(busy2), .tx_done(tx_done2),
        .fifo_count(fifo_count2)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Holds in_valid until the byte is taken; the accepted byte becomes an expectation.
    task automatic applyStimulus(input logic [7:0] d);
        bit taken = 0;
        int n = 0;
        while (!taken && n < 200) begin
            @(negedge clk);
            in_data  = d;
            in_valid = 1'b1;
            taken    = in_ready;
            @(posedge clk);
            if (taken) expQ.push_back(d);
            n++;
        end
        if (!taken) checkOutput("push_timeout", 0, 1);
    endtask

    task automatic dropValid();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic waitDrain(input string name);
        int n = 0;
        while (!(fifo_count == 3'd0 && !busy && expQ.size() == 0) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        checkOutput(name, fifo_count, 0);
        checkOutput({name, "_frames_left"}, expQ.size(), 0);
    endtask

    // Line monitor: decodes one frame per falling edge and checks it against the queue.
    initial begin
        logic [9:0] bits;
        bit aborted;
        bit doneOk;
        bit expectStart = 0;
        forever begin
            @(negedge clk);
            if (expectStart) begin
                checkOutput("gap_one_clk", RsTx, 0);
                expectStart = 0;
            end
            if (rst_n && RsTx == 1'b0) begin
                aborted = 0;
                doneOk  = 1;
                bits    = '0;
                for (int t = 0; t < FRAME; t++) begin
                    if (t > 0) @(negedge clk);
                    if (!rst_n) aborted = 1;
                    if (t % C == C / 2) bits[t / C] = RsTx;
                    if (tx_done !== (t == FRAME - 1)) doneOk = 0;
                end
                if (!aborted) begin
                    checkOutput("start_bit", bits[0], 0);
                    checkOutput("stop_bit", bits[9], 1);
                    checkOutput("tx_done_pos", doneOk, 1);
                    if (expQ.size() == 0) begin
                        checkOutput("unexpected_frame", bits[8:1], 'hxx);
                    end else begin
                        checkOutput("frame_byte", bits[8:1], expQ.pop_front());
                    end
                    expectStart = (expQ.size() != 0);
                    @(negedge clk);
                    checkOutput("gap_idle", {RsTx, busy}, 2'b10);
                end
            end
        end
    end

    initial begin
        int n;
        bit ok;
        int lowCnt;
        in_data = 8'h00; in_valid = 1'b0;
        in_data2 = 8'h00; in_valid2 = 1'b0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;

        // Reset holds everything idle even with in_valid toggling.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            in_valid = ~in_valid;
            in_data  = 8'h3C;
            #1;
            checkOutput("rst_RsTx", RsTx, 1);
            checkOutput("rst_in_ready", in_ready, 0);
            checkOutput("rst_count", fifo_count, 0);
            checkOutput("rst_busy", busy, 0);
        end
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1 checkOutput("release_in_ready", in_ready, 1);

        // Single byte with start-latency check.
        applyStimulus(8'hA5);
        dropValid();
        @(negedge clk);
        checkOutput("latency_n1", RsTx, 1);
        @(negedge clk);
        checkOutput("latency_n2", RsTx, 0);
        waitDrain("drain_single");

        // Burst fills the FIFO; then a push is offered while full with a pop pending.
        applyStimulus(8'h01);
        applyStimulus(8'h02);
        applyStimulus(8'h03);
        applyStimulus(8'h04);
        applyStimulus(8'h05);
        @(negedge clk);
        checkOutput("burst_full_ready", in_ready, 0);
        checkOutput("burst_full_count", fifo_count, 4);
        fork
            applyStimulus(8'h06);
            begin
                n = 0;
                while (tx_done !== 1'b1 && n < 100) begin
                    @(negedge clk);
                    n++;
                end
                checkOutput("fullpop_ready", in_ready, 0);
                checkOutput("fullpop_count", fifo_count, 4);
                @(negedge clk);
                checkOutput("fullpop_count_after", fifo_count, 3);
                checkOutput("fullpop_ready_after", in_ready, 1);
                @(negedge clk);
                checkOutput("fullpop_refill", fifo_count, 4);
            end
        join
        dropValid();
        waitDrain("drain_burst");

        // Reset during data bit 3 of 0xFF.
        applyStimulus(8'hFF);
        dropValid();
        n = 0;
        while (RsTx !== 1'b0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        checkOutput("abort_frame_start", RsTx, 0);
        repeat (17) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("abort_RsTx", RsTx, 1);
        checkOutput("abort_busy", busy, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        expQ.delete();
        ok = 1;
        for (int i = 0; i < 45; i++) begin
            @(negedge clk);
            if (RsTx !== 1'b1 || busy !== 1'b0 || fifo_count !== 3'd0) ok = 0;
        end
        checkOutput("abort_stays_idle", ok, 1);

        // Two stop bits on the second instance with 0x00.
        @(negedge clk);
        in_data2  = 8'h00;
        in_valid2 = 1'b1;
        #1 checkOutput("stop2_ready", in_ready2, 1);
        @(negedge clk);
        in_valid2 = 1'b0;
        n = 0;
        while (RsTx2 !== 1'b0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        lowCnt = 1;
        while (RsTx2 == 1'b0 && lowCnt < 100) begin
            @(negedge clk);
            if (RsTx2 == 1'b0) lowCnt++;
        end
        checkOutput("stop2_low_len", lowCnt, 36);
        ok = 1;
        for (int s = 1; s <= 8; s++) begin
            if (s > 1) @(negedge clk);
            if (RsTx2 !== 1'b1 || tx_done2 !== (s == 8)) ok = 0;
        end
        checkOutput("stop2_high_done", ok, 1);
        @(negedge clk);
        checkOutput("stop2_after", {RsTx2, busy2, tx_done2}, 3'b100);

        repeat (5) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
